pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses via a ready handshake with timeout.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// register-index constants.
package pipeline_pkg;

   // Width of a MIPS register index (rs/rt/rd fields).
   localparam int REG_W = 5;

   // Register $0 is hard-wired to zero and never creates a data hazard.
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Sequencer states: normal flow, or frozen on a slow data-memory access.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction currently in ID.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             ifid_uses_rt_i,
   output logic             load_use_o
);

   // rs is always a source; rt only counts when the ID instruction reads it.
   always_comb begin
      load_use_o = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                   ((idex_rt_i == ifid_rs_i) ||
                    (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Control outputs are
// combinational so they act in the cycle the hazard is seen; mem_error and
// stall_cycles are registered. TIMEOUT must be at least 2.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rt,
   input  logic             ex_branch_taken,
   input  logic             id_jump,
   input  logic             exmem_memaccess,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles,
   output state_t           dbg_state_o
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             mem_error_q, mem_error_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use;
   logic timeout_hit;
   logic freeze;

   hazard_detect u_hazard_detect (
      .idex_memread_i (idex_memread),
      .idex_rt_i      (idex_rt),
      .ifid_rs_i      (ifid_rs),
      .ifid_rt_i      (ifid_rt),
      .ifid_uses_rt_i (ifid_uses_rt),
      .load_use_o     (load_use)
   );

   // Freeze decision: a new unready access in RUN, or still waiting without
   // ready and without having run out of time.
   always_comb begin
      timeout_hit = (state_q == ST_MEM_WAIT) && !dmem_ready &&
                    (to_cnt_q == TO_W'(TIMEOUT - 1));
      freeze      = ((state_q == ST_RUN) && exmem_memaccess && !dmem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !dmem_ready && !timeout_hit);
   end

   // State, timeout counter, sticky error and stall counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         to_cnt_q    <= '0;
         mem_error_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         mem_error_q <= mem_error_d;
         stall_q     <= stall_d;
      end
   end

   // Next state: enter MEM_WAIT on an unready access, leave on ready or timeout.
   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      mem_error_d = mem_error_q;
      case (state_q)
         ST_RUN: begin
            if (exmem_memaccess && !dmem_ready) begin
               state_d  = ST_MEM_WAIT;
               to_cnt_d = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
            end else if (timeout_hit) begin
               state_d     = ST_RUN;
               mem_error_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Pipeline controls by priority: reset, memory freeze, branch, load-use, jump.
   // Load-use outranks jump so the jump is seen again once ID is released.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      if (!reset) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         id_ex_bubble  = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end else if (id_jump) begin
         if_id_flush = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_comb begin
      stall_d = stall_q;
      if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   assign mem_error    = mem_error_q;
   assign stall_cycles = stall_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short timeout and a narrow
// stall counter so both limits are reachable.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;

   // Control bundle order: pc_write, if_id_write, if_id_flush, id_ex_write,
   // id_ex_bubble, ex_mem_write, mem_wb_bubble.
   localparam logic [6:0] C_NORMAL  = 7'b1101010;
   localparam logic [6:0] C_FREEZE  = 7'b0000001;
   localparam logic [6:0] C_RESET   = 7'b0000101;
   localparam logic [6:0] C_LOADUSE = 7'b0001110;
   localparam logic [6:0] C_BRANCH  = 7'b1111110;
   localparam logic [6:0] C_JUMP    = 7'b1111010;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [4:0] ifid_rs, ifid_rt, idex_rt;
   logic ifid_uses_rt, idex_memread, ex_branch_taken, id_jump;
   logic exmem_memaccess, dmem_ready;
   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic ex_mem_write, mem_wb_bubble, mem_error;
   logic [CNT_W-1:0] stall_cycles;
   state_t dbg_state;
   logic [6:0] ctl;

   int errors = 0;
   int checks = 0;

   assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                 id_ex_bubble, ex_mem_write, mem_wb_bubble};

   pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
      .exmem_memaccess(exmem_memaccess), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
      .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
      .mem_error(mem_error), .stall_cycles(stall_cycles),
      .dbg_state_o(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Driver tasks
   task automatic idle();
      ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
      idex_memread = 1'b0; idex_rt = 5'd0;
      ex_branch_taken = 1'b0; id_jump = 1'b0;
      exmem_memaccess = 1'b0; dmem_ready = 1'b0;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      idle();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      idle();
      next_cycle();
      #1;
      checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET); end
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
      checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL reset_mem_error: got %b expected 0", mem_error); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_RUN); end
      reset = 1'b1;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
   endtask

   task automatic test_load_use();
      apply_reset();
      // lw $5 in EX, ID reads rs=5
      idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
      #1;
      checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL loaduse_rs: got %b expected %b", ctl, C_LOADUSE); end
      next_cycle();
      idle();
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL loaduse_after: got %b expected %b", ctl, C_NORMAL); end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL loaduse_stall1: got %0d expected 1", stall_cycles); end
      next_cycle();
      // rt match only counts when the rt source is used
      idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd2; ifid_rt = 5'd7; ifid_uses_rt = 1'b0;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL loaduse_rt_unused: got %b expected %b", ctl, C_NORMAL); end
      ifid_uses_rt = 1'b1;
      #1;
      checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL loaduse_rt_used: got %b expected %b", ctl, C_LOADUSE); end
      next_cycle();
      // $0 never stalls
      idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL loaduse_r0: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
      idle();
      #1;
      checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL loaduse_stall2: got %0d expected 2", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_mem_wait();
      apply_reset();
      exmem_memaccess = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL memwait_freeze%0d: got %b expected %b", i, ctl, C_FREEZE); end
         next_cycle();
      end
      checks++; if (dbg_state !== ST_MEM_WAIT) begin errors++; $display("FAIL memwait_state: got %0d expected %0d", dbg_state, ST_MEM_WAIT); end
      dmem_ready = 1'b1;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL memwait_release: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
      idle();
      #1;
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL memwait_back_run: got %0d expected %0d", dbg_state, ST_RUN); end
      checks++; if (stall_cycles !== 4'd3) begin errors++; $display("FAIL memwait_stall: got %0d expected 3", stall_cycles); end
      next_cycle();
      // zero-wait access
      exmem_memaccess = 1'b1; dmem_ready = 1'b1;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL zerowait_ctl: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
      idle();
      #1;
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL zerowait_state: got %0d expected %0d", dbg_state, ST_RUN); end
      checks++; if (stall_cycles !== 4'd3) begin errors++; $display("FAIL zerowait_stall: got %0d expected 3", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_timeout();
      apply_reset();
      exmem_memaccess = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL timeout_freeze%0d: got %b expected %b", i, ctl, C_FREEZE); end
         checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL timeout_early_err%0d: got %b expected 0", i, mem_error); end
         next_cycle();
      end
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL timeout_release: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
      idle();
      #1;
      checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", mem_error); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL timeout_state: got %0d expected %0d", dbg_state, ST_RUN); end
      checks++; if (stall_cycles !== 4'd8) begin errors++; $display("FAIL timeout_stall: got %0d expected 8", stall_cycles); end
      for (int i = 0; i < 3; i++) next_cycle();
      checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected 1", mem_error); end
      reset = 1'b0;
      #1;
      checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL timeout_err_cleared: got %b expected 0", mem_error); end
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_priority();
      apply_reset();
      ex_branch_taken = 1'b1;
      idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
      #1;
      checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_over_loaduse: got %b expected %b", ctl, C_BRANCH); end
      next_cycle();
      idle();
      // branch while frozen: no flush until release
      exmem_memaccess = 1'b1; ex_branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL branch_in_wait%0d: got %b expected %b", i, ctl, C_FREEZE); end
         next_cycle();
      end
      dmem_ready = 1'b1;
      #1;
      checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_at_release: got %b expected %b", ctl, C_BRANCH); end
      next_cycle();
      idle();
      #1;
      checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL priority_stall: got %0d expected 2", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_jump();
      apply_reset();
      id_jump = 1'b1;
      #1;
      checks++; if (ctl !== C_JUMP) begin errors++; $display("FAIL jump_alone: got %b expected %b", ctl, C_JUMP); end
      next_cycle();
      idex_memread = 1'b1; idex_rt = 5'd6; ifid_rs = 5'd6;
      #1;
      checks++; if (ctl !== C_LOADUSE) begin errors++; $display("FAIL jump_vs_loaduse_1: got %b expected %b", ctl, C_LOADUSE); end
      next_cycle();
      idex_memread = 1'b0;
      #1;
      checks++; if (ctl !== C_JUMP) begin errors++; $display("FAIL jump_vs_loaduse_2: got %b expected %b", ctl, C_JUMP); end
      next_cycle();
      idle();
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      exmem_memaccess = 1'b1; dmem_ready = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      checks++; if (dbg_state !== ST_MEM_WAIT) begin errors++; $display("FAIL midwait_state_before: got %0d expected %0d", dbg_state, ST_MEM_WAIT); end
      checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL midwait_stall_before: got %0d expected 2", stall_cycles); end
      reset = 1'b0;
      #1;
      checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL midwait_reset_ctl: got %b expected %b", ctl, C_RESET); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL midwait_reset_state: got %0d expected %0d", dbg_state, ST_RUN); end
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL midwait_reset_stall: got %0d expected 0", stall_cycles); end
      next_cycle();
      idle();
      reset = 1'b1;
      #1;
      checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL midwait_after_release: got %b expected %b", ctl, C_NORMAL); end
      next_cycle();
   endtask

   task automatic test_saturation();
      apply_reset();
      idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
      for (int i = 0; i < 18; i++) next_cycle();
      checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_saturate: got %0d expected 15", stall_cycles); end
      idle();
      next_cycle();
      checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_hold_sat: got %0d expected 15", stall_cycles); end
   endtask

   // Test sequence and final report
   initial begin
      idle();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_timeout();
      test_priority();
      test_jump();
      test_reset_mid_wait();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
